// File: rtl/writeback_merge_pkg.sv
// Shared writeback types for the execute/writeback slice.
//  wbPkt     - result packet written to the register file / active list
//  bypassPkt - tag/data broadcast to all execute lanes
//  WB_MERGE_DEPTH - default collision FIFO depth for writeback_merge
package writeback_merge_pkg;

    localparam int DATA_W         = 32;
    localparam int PHY_W          = 7;
    localparam int AL_W           = 5;
    localparam int WB_MERGE_DEPTH = 2;

    typedef struct packed {
        logic              valid;
        logic              destValid;
        logic [PHY_W-1:0]  phyDest;
        logic [DATA_W-1:0] destData;
        logic [AL_W-1:0]   alId;
    } wbPkt;

    typedef struct packed {
        logic              valid;
        logic [PHY_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } bypassPkt;

    // Bypass only broadcasts results that actually write a destination.
    function automatic bypassPkt to_bypass(input wbPkt p);
        bypassPkt b;
        b.valid = p.valid & p.destValid;
        b.tag   = p.phyDest;
        b.data  = p.destData;
        return b;
    endfunction

endpackage

// File: rtl/writeback_merge_if.sv
// Writeback merge bus: the two execute results in, the merged writeback and
// bypass out, plus recovery, stall and overflow.
//  slave  - the merger (consumes results, produces writeback)
//  master - the execute lane / surrounding pipeline
interface writeback_merge_if;
    import writeback_merge_pkg::*;

    logic     recoverFlag;
    wbPkt     wbPacketS;
    wbPkt     wbPacketC;
    wbPkt     wbPacket;
    bypassPkt bypassPacket;
    logic     stall;
    logic     overflow;

    modport master (
        output recoverFlag, wbPacketS, wbPacketC,
        input  wbPacket, bypassPacket, stall, overflow
    );

    modport slave (
        input  recoverFlag, wbPacketS, wbPacketC,
        output wbPacket, bypassPacket, stall, overflow
    );

endinterface

// File: rtl/writeback_merge_fifo.sv
// Collision FIFO for writeback_merge: DEPTH wbPkt entries, two ordered write
// ports (wr1 is only used together with wr0 and lands behind it), one read
// port (head is a combinational view of the oldest entry), synchronous flush.
//  clk, reset          - clock, async active-high reset (control only)
//  flush               - empty the FIFO, ignore writes/read this cycle
//  wr0_en/wr0_data     - first enqueue
//  wr1_en/wr1_data     - second enqueue (behind wr0)
//  rd_en               - dequeue head
//  head                - oldest entry
//  count, count_next   - occupancy now and after this cycle's update
module writeback_merge_fifo
    import writeback_merge_pkg::*;
#(
    parameter  int DEPTH = WB_MERGE_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr0_en,
    input  wbPkt             wr0_data,
    input  logic             wr1_en,
    input  wbPkt             wr1_data,
    input  logic             rd_en,
    output wbPkt             head,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next
);

    localparam logic [PTR_W+1:0] DEPTH_P = (PTR_W + 2)'(DEPTH);

    wbPkt             mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Pointer advance by 0..2 modulo DEPTH; one subtraction suffices since
    // ptr + 2 < 2*DEPTH for DEPTH >= 2.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                                  input logic [1:0] n);
        logic [PTR_W+1:0] s;
        s = {2'b00, p} + {{PTR_W{1'b0}}, n};
        if (s >= DEPTH_P) s = s - DEPTH_P;
        return s[PTR_W-1:0];
    endfunction

    assign head = mem[rd_ptr];

    always_comb begin
        count_next = count + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(rd_en);
        if (flush) count_next = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= wrap_add(rd_ptr, {1'b0, rd_en});
            wr_ptr <= wrap_add(wr_ptr, {1'b0, wr0_en} + {1'b0, wr1_en});
            count  <= count_next;
        end
    end

    // Storage carries no reset; entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (wr0_en) mem[wr_ptr] <= wr0_data;
            if (wr1_en) mem[wrap_add(wr_ptr, 2'd1)] <= wr1_data;
        end
    end

endmodule

// File: rtl/writeback_merge.sv
// Per-lane writeback merger. Orders the simple-ALU and complex-ALU result
// streams (FIFO head, then complex, then simple), registers one wbPkt per
// cycle with a matching bypass broadcast, parks losers in a collision FIFO,
// raises stall when at most one free slot remains and flags overflow
// (sticky until reset) if a result must be dropped.
//  clk, reset   - core clock, async active-high reset
//  bus (slave)  - recoverFlag, wbPacketS, wbPacketC in;
//                 wbPacket, bypassPacket, stall, overflow out
// Optional build macro WB_MERGE_PERF_EN adds:
//  perfCollide_o[31:0] - saturating count of cycles with both inputs valid
//  perfStall_o[31:0]   - saturating count of cycles with stall high
module writeback_merge
    import writeback_merge_pkg::*;
#(
    parameter int DEPTH = WB_MERGE_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    writeback_merge_if.slave  bus
`ifdef WB_MERGE_PERF_EN
    ,
    output logic [31:0]       perfCollide_o,
    output logic [31:0]       perfStall_o
`endif
);

    localparam int              CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(DEPTH);

    wbPkt             head_p0;
    wbPkt             sel_pkt_p0;
    wbPkt             wr0_data_p0;
    logic             vld_p0;
    logic             empty_p0;
    logic             deq_p0;
    logic             enq_c_p0;
    logic             enq_s_p0;
    logic [1:0]       n_req_p0;
    logic [1:0]       n_acc_p0;
    logic [CNT_W:0]   space_p0;
    logic             drop_p0;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    wbPkt             out_pkt_p1;
    logic             stall_p1;
    logic             overflow_p1;

    // ---- stage p0: select winner, route losers into the FIFO ----
    always_comb begin
        empty_p0 = (count == '0);
        deq_p0   = !empty_p0 && !bus.recoverFlag;
        enq_c_p0 = !empty_p0 && bus.wbPacketC.valid;
        enq_s_p0 = bus.wbPacketS.valid && (!empty_p0 || bus.wbPacketC.valid);
        n_req_p0 = {1'b0, enq_c_p0} + {1'b0, enq_s_p0};
        // Free slots counting the head that leaves this cycle.
        space_p0 = DEPTH_C - {1'b0, count} + (CNT_W + 1)'(!empty_p0);
        n_acc_p0 = n_req_p0;
        drop_p0  = 1'b0;
        if (bus.recoverFlag) begin
            n_acc_p0 = 2'd0;
        end else if ((CNT_W + 1)'(n_req_p0) > space_p0) begin
            // Only possible when space < 2, so it fits in two bits; the
            // younger packet (simple) is the one lost.
            n_acc_p0 = space_p0[1:0];
            drop_p0  = 1'b1;
        end
        wr0_data_p0 = enq_c_p0 ? bus.wbPacketC : bus.wbPacketS;

        vld_p0     = !empty_p0 || bus.wbPacketC.valid || bus.wbPacketS.valid;
        sel_pkt_p0 = bus.wbPacketS;
        if (!empty_p0)                  sel_pkt_p0 = head_p0;
        else if (bus.wbPacketC.valid)   sel_pkt_p0 = bus.wbPacketC;
    end

    writeback_merge_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (bus.recoverFlag),
        .wr0_en     (n_acc_p0 != 2'd0),
        .wr0_data   (wr0_data_p0),
        .wr1_en     (n_acc_p0 == 2'd2),
        .wr1_data   (bus.wbPacketS),
        .rd_en      (deq_p0),
        .head       (head_p0),
        .count      (count),
        .count_next (count_next)
    );

    // ---- stage p1: registered writeback, stall and overflow ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_pkt_p1  <= '0;
            stall_p1    <= 1'b0;
            overflow_p1 <= 1'b0;
        end else begin
            if (bus.recoverFlag) begin
                out_pkt_p1.valid <= 1'b0;
                stall_p1         <= 1'b0;
            end else begin
                if (vld_p0) out_pkt_p1       <= sel_pkt_p0;
                else        out_pkt_p1.valid <= 1'b0;
                // One slot stays free for a complex result already in flight.
                stall_p1 <= (count_next >= CNT_W'(DEPTH - 1));
            end
            if (drop_p0) overflow_p1 <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (!drop_p0)
            else $warning("writeback_merge: enqueue while full, packet dropped");
        end
    end

    assign bus.wbPacket     = out_pkt_p1;
    assign bus.bypassPacket = to_bypass(out_pkt_p1);
    assign bus.stall        = stall_p1;
    assign bus.overflow     = overflow_p1;

`ifdef WB_MERGE_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perfCollide_o <= '0;
            perfStall_o   <= '0;
        end else begin
            if (bus.wbPacketC.valid && bus.wbPacketS.valid && perfCollide_o != '1)
                perfCollide_o <= perfCollide_o + 32'd1;
            if (stall_p1 && perfStall_o != '1)
                perfStall_o <= perfStall_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_merge.sv
module tb_writeback_merge;
    import writeback_merge_pkg::*;

    localparam int DEPTH = WB_MERGE_DEPTH;

    typedef struct {
        logic valid;
        wbPkt pkt;
        logic stall;
        logic ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    writeback_merge_if bus();

`ifdef WB_MERGE_PERF_EN
    logic [31:0] perf_collide;
    logic [31:0] perf_stall;
`endif

    writeback_merge #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef WB_MERGE_PERF_EN
        ,
        .perfCollide_o (perf_collide),
        .perfStall_o   (perf_stall)
`endif
    );

    exp_t exp_q[$];
    wbPkt model_q[$];
    logic model_ovf   = 1'b0;
    logic model_stall = 1'b0;
    int   collide_cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic wbPkt mk(input int dest, input logic [31:0] data);
        wbPkt p;
        p = '0;
        p.valid     = 1'b1;
        p.destValid = 1'b1;
        p.phyDest   = PHY_W'(dest);
        p.destData  = data;
        p.alId      = AL_W'(dest);
        return p;
    endfunction

    function automatic wbPkt rnd_pkt(input logic v);
        wbPkt p;
        p.valid     = v;
        p.destValid = 1'(($urandom_range(0, 3) != 0));
        p.phyDest   = PHY_W'($urandom);
        p.destData  = $urandom;
        p.alId      = AL_W'($urandom);
        return p;
    endfunction

    // Reference: everything pending this cycle in age order is the old FIFO
    // contents, then complex, then simple. The oldest goes out; at most DEPTH
    // of the rest survive, the youngest beyond that are dropped.
    task automatic step(input logic rec, input wbPkt c, input wbPkt s);
        exp_t e;
        wbPkt pend[$];
        @(negedge clk);
        bus.recoverFlag = rec;
        bus.wbPacketC   = c;
        bus.wbPacketS   = s;
        if (c.valid && s.valid) collide_cnt++;
        e.pkt = '0;
        if (rec) begin
            model_q.delete();
            e.valid = 1'b0;
            e.stall = 1'b0;
        end else begin
            pend = model_q;
            if (c.valid) pend.push_back(c);
            if (s.valid) pend.push_back(s);
            e.valid = (pend.size() != 0);
            if (e.valid) e.pkt = pend.pop_front();
            if (pend.size() > DEPTH) begin
                model_ovf = 1'b1;
                while (pend.size() > DEPTH) void'(pend.pop_back());
            end
            model_q = pend;
            e.stall = (model_q.size() >= DEPTH - 1);
        end
        model_stall = e.stall;
        e.ovf = model_ovf;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0);
    endtask

    // Scoreboard monitor: one expectation per clocked cycle issued by step().
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_valid", 64'(bus.wbPacket.valid), 64'(e.valid));
                if (e.valid) begin
                    check("out_pkt", 64'(bus.wbPacket), 64'(e.pkt));
                    check("byp_valid", 64'(bus.bypassPacket.valid), 64'(e.pkt.destValid));
                    check("byp_tag", 64'(bus.bypassPacket.tag), 64'(e.pkt.phyDest));
                    check("byp_data", 64'(bus.bypassPacket.data), 64'(e.pkt.destData));
                end else begin
                    check("byp_valid_idle", 64'(bus.bypassPacket.valid), 64'd0);
                end
                check("stall", 64'(bus.stall), 64'(e.stall));
                check("overflow", 64'(bus.overflow), 64'(e.ovf));
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_pkt"}, 64'(bus.wbPacket), 64'd0);
        check({tag, "_byp"}, 64'(bus.bypassPacket.valid), 64'd0);
        check({tag, "_stall"}, 64'(bus.stall), 64'd0);
        check({tag, "_ovf"}, 64'(bus.overflow), 64'd0);
    endtask

    initial begin
        wbPkt c, s;
        int guard;
        reset           = 1'b1;
        bus.recoverFlag = 1'b0;
        bus.wbPacketC   = '0;
        bus.wbPacketS   = '0;
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // S alone
        step(1'b0, '0, mk(5, 32'h11));
        idle(2);
        // S and C together: complex first, simple next
        step(1'b0, mk(7, 32'h77), mk(9, 32'h99));
        idle(3);
        // FIFO at two entries, then recovery with S valid
        step(1'b0, mk(1, 32'hA1), mk(2, 32'hA2));
        step(1'b0, mk(3, 32'hA3), mk(4, 32'hA4));
        step(1'b1, '0, mk(6, 32'hA6));
        idle(3);
        // Three collisions in a row: third drops a packet and sets overflow
        for (int i = 0; i < 3; i++)
            step(1'b0, mk(16 + i, 32'hC0 + i), mk(32 + i, 32'h50 + i));
        idle(4);
        // One buffered entry, then async reset mid-cycle
        step(1'b0, mk(40, 32'hB0), mk(41, 32'hB1));
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        model_q.delete();
        model_ovf   = 1'b0;
        model_stall = 1'b0;
        collide_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        bus.recoverFlag = 1'b0;
        bus.wbPacketC   = '0;
        bus.wbPacketS   = '0;
        reset = 1'b0;
        idle(3);

        // Random traffic; issue respects stall, complex may still arrive
        for (int i = 0; i < 400; i++) begin
            c = rnd_pkt(1'($urandom_range(0, 3) == 0));
            s = rnd_pkt(!model_stall && 1'($urandom_range(0, 1)));
            step(1'($urandom_range(0, 24) == 0), c, s);
        end
        idle(4);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
`ifdef WB_MERGE_PERF_EN
        check("perf_collide", 64'(perf_collide), 64'(collide_cnt));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
